// File: rtl/cby_param.sv
// Parametrised Y-direction connection block: vertical channel pass-through plus
// NUM_IPIN gated pin muxes whose selects are loaded serially over prog_clk.
module cby_param #(
   parameter int CHAN_W   = 20,
   parameter int NUM_IPIN = 7,
   parameter int MUX_SIZE = 8
) (
   input  logic                prog_clk,
   input  logic                pReset,
   input  logic                ccff_en,
   input  logic                ccff_head,
   output logic                ccff_tail,
   input  logic [CHAN_W-1:0]   chany_bottom_in,
   input  logic [CHAN_W-1:0]   chany_top_in,
   output logic [CHAN_W-1:0]   chany_top_out,
   output logic [CHAN_W-1:0]   chany_bottom_out,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic                cfg_done
);

   localparam int SEL_W    = $clog2(MUX_SIZE);
   localparam int CFG_BITS = NUM_IPIN * SEL_W;
   localparam int STRIDE   = CHAN_W / (MUX_SIZE / 2);
   localparam int CNT_W    = $clog2(CFG_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

   logic [CFG_BITS-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                done_q, done_d;
   logic                tail_q, tail_d;

   logic [MUX_SIZE-1:0] mux_in_s [NUM_IPIN];
   logic [SEL_W-1:0]    sel_s    [NUM_IPIN];

   assign chany_top_out    = chany_bottom_in;
   assign chany_bottom_out = chany_top_in;

   // Chain shift, saturating bit count and done flag; everything holds while disabled.
   always_comb begin
      cfg_d  = cfg_q;
      cnt_d  = cnt_q;
      tail_d = tail_q;
      done_d = done_q;
      if (ccff_en) begin
         cfg_d  = {cfg_q[CFG_BITS-2:0], ccff_head};
         tail_d = cfg_q[CFG_BITS-1];
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = cnt_q;
         end
      end else begin
         cfg_d = cfg_q;
      end
      if (cnt_d == CNT_MAX) begin
         done_d = 1'b1;
      end else begin
         done_d = done_q;
      end
   end

   // Configuration state register; reset discards any partially loaded frame.
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         cfg_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
         tail_q <= 1'b0;
      end else begin
         cfg_q  <= cfg_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
         tail_q <= tail_d;
      end
   end

   assign ccff_tail = tail_q;
   assign cfg_done  = done_q;

   // Input pair p of pin k taps track (k + p*STRIDE) mod CHAN_W; even from below, odd from above.
   for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
      for (genvar j = 0; j < MUX_SIZE; j++) begin : g_in
         localparam int T = (k + (j / 2) * STRIDE) % CHAN_W;
         if ((j % 2) == 0) begin : g_bot
            assign mux_in_s[k][j] = chany_bottom_in[T];
         end else begin : g_top
            assign mux_in_s[k][j] = chany_top_in[T];
         end
      end
      assign sel_s[k]    = cfg_q[k*SEL_W +: SEL_W];
      assign ipin_out[k] = (done_q && !ccff_en) ? mux_in_s[k][sel_s[k]] : 1'b0;
   end

endmodule
